// File: rtl/pipe_fetch_stage_pkg.sv
// Shared Y86-64 encodings: icodes, register "none" code, fetch status and decode helpers.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    function automatic logic f_need_regids(input logic [3:0] icode);
        case (icode)
            IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic f_need_valc(input logic [3:0] icode);
        case (icode)
            IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_fetch_stage_if.sv
// Instruction-memory port of the fetch stage: fetch address out, 10 instruction bytes and error back.
interface pipe_fetch_stage_if #(
    parameter int PC_W = 64
);
    logic [PC_W-1:0] imem_addr;
    logic [79:0]     imem_data;
    logic            imem_error;

    modport master (output imem_addr, input imem_data, input imem_error);
    modport slave  (input imem_addr, output imem_data, output imem_error);
endinterface

// File: rtl/pipe_fetch_stage_fetch_align.sv
// Combinational split of the 10 fetched bytes into icode/ifun/rA/rB/valC plus length and validity flags.
module fetch_align
    import y86_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [79:0]     i_data,
    input  logic            i_error,
    output logic [3:0]      o_icode,
    output logic [3:0]      o_ifun,
    output logic [3:0]      o_ra,
    output logic [3:0]      o_rb,
    output logic [PC_W-1:0] o_valc,
    output logic            o_need_regids,
    output logic            o_need_valc,
    output logic            o_instr_valid
);
    logic [63:0] w_word;

    always_comb begin
        o_icode       = i_error ? INOP : i_data[7:4];
        o_ifun        = i_error ? 4'h0 : i_data[3:0];
        o_instr_valid = (o_icode <= IPOPQ);
        o_need_regids = f_need_regids(o_icode);
        o_need_valc   = f_need_valc(o_icode);
        o_ra          = o_need_regids ? i_data[15:12] : RNONE;
        o_rb          = o_need_regids ? i_data[11:8]  : RNONE;
        // constant word starts after the register byte only when one is present
        w_word        = o_need_regids ? i_data[79:16] : i_data[71:8];
        o_valc        = o_need_valc ? PC_W'(w_word) : '0;
    end

endmodule

// File: rtl/pipe_fetch_stage.sv
// Y86-64 fetch stage with F and D pipeline registers.
// Optional macro PIPE_FETCH_PERF_EN adds fetched/bubble performance counters.
module pipe_fetch_stage
    import y86_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic [3:0]        M_icode,
    input  logic              M_Cnd,
    input  logic [PC_W-1:0]   M_valA,
    input  logic [3:0]        W_icode,
    input  logic [PC_W-1:0]   W_valM,
    pipe_fetch_stage_if.master imem,
    output logic [PC_W-1:0]   f_predPC,
    output logic [2:0]        D_stat,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [PC_W-1:0]   D_valC,
    output logic [PC_W-1:0]   D_valP
`ifdef PIPE_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);
    logic [PC_W-1:0] r_f_predpc;
    logic [PC_W-1:0] w_f_pc;
    logic [PC_W-1:0] w_valp;
    logic [PC_W-1:0] w_valc;
    logic [3:0]      w_icode, w_ifun, w_ra, w_rb, w_len;
    logic            w_need_regids, w_need_valc, w_instr_valid;
    stat_e           w_stat;

    stat_e           r_d_stat;
    logic [3:0]      r_d_icode, r_d_ifun, r_d_ra, r_d_rb;
    logic [PC_W-1:0] r_d_valc, r_d_valp;

    fetch_align #(.PC_W(PC_W)) u_align (
        .i_data        (imem.imem_data),
        .i_error       (imem.imem_error),
        .o_icode       (w_icode),
        .o_ifun        (w_ifun),
        .o_ra          (w_ra),
        .o_rb          (w_rb),
        .o_valc        (w_valc),
        .o_need_regids (w_need_regids),
        .o_need_valc   (w_need_valc),
        .o_instr_valid (w_instr_valid)
    );

    always_comb begin
        // mispredicted not-taken jump outranks a returning ret
        if (M_icode == IJXX && !M_Cnd)
            w_f_pc = M_valA;
        else if (W_icode == IRET)
            w_f_pc = W_valM;
        else
            w_f_pc = r_f_predpc;

        w_len  = 4'd1 + {3'b000, w_need_regids} + (w_need_valc ? 4'd8 : 4'd0);
        w_valp = w_f_pc + PC_W'(w_len);
        f_predPC = (w_icode == IJXX || w_icode == ICALL) ? w_valc : w_valp;

        if (imem.imem_error)
            w_stat = SADR;
        else if (!w_instr_valid)
            w_stat = SINS;
        else if (w_icode == IHALT)
            w_stat = SHLT;
        else
            w_stat = SAOK;
    end

    assign imem.imem_addr = w_f_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_f_predpc <= RESET_PC;
        else if (!F_stall)
            r_f_predpc <= f_predPC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || (!D_stall && D_bubble)) begin
            r_d_stat  <= SAOK;
            r_d_icode <= INOP;
            r_d_ifun  <= 4'h0;
            r_d_ra    <= RNONE;
            r_d_rb    <= RNONE;
            r_d_valc  <= '0;
            r_d_valp  <= '0;
        end else if (!D_stall) begin
            r_d_stat  <= w_stat;
            r_d_icode <= w_icode;
            r_d_ifun  <= w_ifun;
            r_d_ra    <= w_ra;
            r_d_rb    <= w_rb;
            r_d_valc  <= w_valc;
            r_d_valp  <= w_valp;
        end
    end

    assign D_stat  = r_d_stat;
    assign D_icode = r_d_icode;
    assign D_ifun  = r_d_ifun;
    assign D_rA    = r_d_ra;
    assign D_rB    = r_d_rb;
    assign D_valC  = r_d_valc;
    assign D_valP  = r_d_valp;

`ifdef PIPE_FETCH_PERF_EN
    logic [31:0] r_perf_fetched, r_perf_bubbles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else if (!D_stall) begin
            if (D_bubble)
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            else
                r_perf_fetched <= r_perf_fetched + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Directed self-checking bench for pipe_fetch_stage; perf counter checks build when PIPE_FETCH_PERF_EN is defined.
module tb_pipe_fetch_stage;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, F_stall, D_stall, D_bubble, M_Cnd;
    logic [3:0]  M_icode, W_icode;
    logic [63:0] M_valA, W_valM, f_predPC, D_valC, D_valP;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
`ifdef PIPE_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pipe_fetch_stage_if #(.PC_W(64)) imem_if ();

    pipe_fetch_stage #(.PC_W(64), .RESET_PC(64'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .M_icode  (M_icode),
        .M_Cnd    (M_Cnd),
        .M_valA   (M_valA),
        .W_icode  (W_icode),
        .W_valM   (W_valM),
        .imem     (imem_if.master),
        .f_predPC (f_predPC),
        .D_stat   (D_stat),
        .D_icode  (D_icode),
        .D_ifun   (D_ifun),
        .D_rA     (D_rA),
        .D_rB     (D_rB),
        .D_valC   (D_valC),
        .D_valP   (D_valP)
`ifdef PIPE_FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (imem_if.imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_if.imem_addr, 64'h0); end
        n_checks++; if (D_icode !== 4'h1) begin n_fail++; $display("FAIL reset_icode: got %h want 1", D_icode); end
        n_checks++; if (D_stat !== 3'd1) begin n_fail++; $display("FAIL reset_stat: got %0d want 1", D_stat); end
        n_checks++; if (D_rA !== 4'hF) begin n_fail++; $display("FAIL reset_rA: got %h want F", D_rA); end
        n_checks++; if (D_valP !== 64'h0) begin n_fail++; $display("FAIL reset_valP: got %h want 0", D_valP); end
        imem_if.imem_data = {64'h100, 8'hF2, 8'h30};
        rst_n = 1'b1;
        #1;
        n_checks++; if (f_predPC !== 64'd10) begin n_fail++; $display("FAIL irmovq_predpc: got %h want a", f_predPC); end
        step();
        n_checks++; if (D_icode !== 4'h3) begin n_fail++; $display("FAIL irmovq_icode: got %h want 3", D_icode); end
        n_checks++; if (D_rA !== 4'hF || D_rB !== 4'h2) begin n_fail++; $display("FAIL irmovq_regs: got %h%h want F2", D_rA, D_rB); end
        n_checks++; if (D_valC !== 64'h100) begin n_fail++; $display("FAIL irmovq_valC: got %h want 100", D_valC); end
        n_checks++; if (D_valP !== 64'd10) begin n_fail++; $display("FAIL irmovq_valP: got %h want a", D_valP); end
        n_checks++; if (imem_if.imem_addr !== 64'd10) begin n_fail++; $display("FAIL irmovq_next_pc: got %h want a", imem_if.imem_addr); end
    endtask

    task automatic test_jump();
        imem_if.imem_data = {8'h00, 64'h20, 8'h70};
        step();
        n_checks++; if (imem_if.imem_addr !== 64'h20) begin n_fail++; $display("FAIL jmp1_target: got %h want 20", imem_if.imem_addr); end
        n_checks++; if (D_valP !== 64'h13) begin n_fail++; $display("FAIL jmp1_valP: got %h want 13", D_valP); end
        imem_if.imem_data = {8'h00, 64'h80, 8'h70};
        #1;
        n_checks++; if (f_predPC !== 64'h80) begin n_fail++; $display("FAIL jmp2_predpc: got %h want 80", f_predPC); end
        step();
        n_checks++; if (D_valP !== 64'h29) begin n_fail++; $display("FAIL jmp2_valP: got %h want 29", D_valP); end
        n_checks++; if (D_valC !== 64'h80 || D_icode !== 4'h7) begin n_fail++; $display("FAIL jmp2_fields: got %h/%h want 80/7", D_valC, D_icode); end
        n_checks++; if (imem_if.imem_addr !== 64'h80) begin n_fail++; $display("FAIL jmp2_next_pc: got %h want 80", imem_if.imem_addr); end
        M_icode = 4'h7; M_Cnd = 1'b1; M_valA = 64'h29;
        #1;
        n_checks++; if (imem_if.imem_addr !== 64'h80) begin n_fail++; $display("FAIL taken_no_redirect: got %h want 80", imem_if.imem_addr); end
        M_Cnd = 1'b0;
        #1;
        n_checks++; if (imem_if.imem_addr !== 64'h29) begin n_fail++; $display("FAIL mispredict_redirect: got %h want 29", imem_if.imem_addr); end
        imem_if.imem_data = {64'h0, 8'h00, 8'h10};
        step();
        M_icode = 4'h0;
        #1;
        n_checks++; if (imem_if.imem_addr !== 64'h2a) begin n_fail++; $display("FAIL after_redirect_pc: got %h want 2a", imem_if.imem_addr); end
        n_checks++; if (D_valP !== 64'h2a || D_icode !== 4'h1) begin n_fail++; $display("FAIL redirect_nop: got %h/%h want 2a/1", D_valP, D_icode); end
    endtask

    task automatic test_ret();
        F_stall = 1'b1; D_bubble = 1'b1; W_icode = 4'h9; W_valM = 64'h400;
        imem_if.imem_data = {64'h0, 8'h00, 8'h10};
        #1;
        n_checks++; if (imem_if.imem_addr !== 64'h400) begin n_fail++; $display("FAIL ret_redirect: got %h want 400", imem_if.imem_addr); end
        step();
        W_icode = 4'h0;
        #1;
        n_checks++; if (imem_if.imem_addr !== 64'h2a) begin n_fail++; $display("FAIL ret_fstall_hold: got %h want 2a", imem_if.imem_addr); end
        n_checks++; if (D_icode !== 4'h1 || D_valP !== 64'h0) begin n_fail++; $display("FAIL ret_bubble: got %h/%h want 1/0", D_icode, D_valP); end
        F_stall = 1'b0; D_bubble = 1'b0;
    endtask

    task automatic test_stall_bubble();
        imem_if.imem_data = {64'h0, 8'h12, 8'h20};
        step();
        n_checks++; if (D_icode !== 4'h2 || D_rA !== 4'h1 || D_rB !== 4'h2) begin n_fail++; $display("FAIL rrmovq_fields: got %h %h %h want 2 1 2", D_icode, D_rA, D_rB); end
        n_checks++; if (D_valP !== 64'h2c || D_valC !== 64'h0) begin n_fail++; $display("FAIL rrmovq_valP_valC: got %h/%h want 2c/0", D_valP, D_valC); end
        F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1;
        imem_if.imem_data = {64'h0, 8'h34, 8'h60};
        step();
        n_checks++; if (D_icode !== 4'h2 || D_rA !== 4'h1 || D_valP !== 64'h2c) begin n_fail++; $display("FAIL stall_over_bubble: got %h %h %h want 2 1 2c", D_icode, D_rA, D_valP); end
        n_checks++; if (imem_if.imem_addr !== 64'h2c) begin n_fail++; $display("FAIL fstall_pc: got %h want 2c", imem_if.imem_addr); end
        D_stall = 1'b0;
        step();
        n_checks++; if (D_icode !== 4'h1 || D_rA !== 4'hF || D_rB !== 4'hF || D_stat !== 3'd1 || D_valP !== 64'h0) begin n_fail++; $display("FAIL bubble_values: got %h %h %h %0d %h want 1 F F 1 0", D_icode, D_rA, D_rB, D_stat, D_valP); end
        D_bubble = 1'b0;
        step();
        n_checks++; if (D_icode !== 4'h6 || D_rA !== 4'h3 || D_rB !== 4'h4 || D_valP !== 64'h2e) begin n_fail++; $display("FAIL opq_load: got %h %h %h %h want 6 3 4 2e", D_icode, D_rA, D_rB, D_valP); end
    endtask

    task automatic test_status();
        imem_if.imem_error = 1'b1;
        imem_if.imem_data = {64'h100, 8'hF2, 8'h30};
        step();
        n_checks++; if (D_stat !== 3'd3 || D_icode !== 4'h1 || D_ifun !== 4'h0) begin n_fail++; $display("FAIL imem_error: got %0d %h %h want 3 1 0", D_stat, D_icode, D_ifun); end
        n_checks++; if (D_valP !== 64'h2d || D_valC !== 64'h0) begin n_fail++; $display("FAIL imem_error_len: got %h/%h want 2d/0", D_valP, D_valC); end
        imem_if.imem_data = {64'h0, 8'h00, 8'hC0};
        step();
        n_checks++; if (D_stat !== 3'd3) begin n_fail++; $display("FAIL adr_over_ins: got %0d want 3", D_stat); end
        imem_if.imem_error = 1'b0;
        step();
        n_checks++; if (D_stat !== 3'd4 || D_icode !== 4'hC) begin n_fail++; $display("FAIL invalid_icode: got %0d %h want 4 C", D_stat, D_icode); end
        imem_if.imem_data = {64'h0, 8'h00, 8'h00};
        step();
        n_checks++; if (D_stat !== 3'd2 || D_valP !== 64'h2d || D_rA !== 4'hF) begin n_fail++; $display("FAIL halt: got %0d %h %h want 2 2d F", D_stat, D_valP, D_rA); end
        F_stall = 1'b0;
    endtask

    task automatic test_call_wrap();
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = '1;
        imem_if.imem_data = {64'h100, 8'hF2, 8'h30};
        #1;
        n_checks++; if (f_predPC !== 64'h9) begin n_fail++; $display("FAIL valp_wrap_pred: got %h want 9", f_predPC); end
        step();
        M_icode = 4'h0;
        #1;
        n_checks++; if (D_valP !== 64'h9 || imem_if.imem_addr !== 64'h9) begin n_fail++; $display("FAIL valp_wrap: got %h/%h want 9/9", D_valP, imem_if.imem_addr); end
        imem_if.imem_data = {8'h00, 64'h500, 8'h80};
        #1;
        n_checks++; if (f_predPC !== 64'h500) begin n_fail++; $display("FAIL call_pred: got %h want 500", f_predPC); end
        step();
        n_checks++; if (D_icode !== 4'h8 || D_valP !== 64'h12 || D_valC !== 64'h500) begin n_fail++; $display("FAIL call_fields: got %h %h %h want 8 12 500", D_icode, D_valP, D_valC); end
        n_checks++; if (imem_if.imem_addr !== 64'h500) begin n_fail++; $display("FAIL call_next_pc: got %h want 500", imem_if.imem_addr); end
    endtask

`ifdef PIPE_FETCH_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        imem_if.imem_data = {64'h0, 8'h00, 8'h10};
        n_checks++; if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0) begin n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_fetched, perf_bubbles); end
        repeat (5) step();
        D_bubble = 1'b1;
        repeat (2) step();
        D_stall = 1'b1;
        step();
        D_stall = 1'b0; D_bubble = 1'b0;
        n_checks++; if (perf_fetched !== 32'd5) begin n_fail++; $display("FAIL perf_fetched: got %0d want 5", perf_fetched); end
        n_checks++; if (perf_bubbles !== 32'd2) begin n_fail++; $display("FAIL perf_bubbles: got %0d want 2", perf_bubbles); end
        step();
    endtask
`endif

    task automatic test_async_reset();
        imem_if.imem_data = {64'h100, 8'hF2, 8'h30};
        step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (D_icode !== 4'h1 || D_valP !== 64'h0 || D_valC !== 64'h0 || D_rB !== 4'hF) begin n_fail++; $display("FAIL async_reset_D: got %h %h %h %h want 1 0 0 F", D_icode, D_valP, D_valC, D_rB); end
        n_checks++; if (imem_if.imem_addr !== 64'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h want 0", imem_if.imem_addr); end
`ifdef PIPE_FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0) begin n_fail++; $display("FAIL async_reset_perf: got %0d/%0d want 0/0", perf_fetched, perf_bubbles); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        M_icode = 4'h0; M_Cnd = 1'b0; M_valA = '0; W_icode = 4'h0; W_valM = '0;
        imem_if.imem_data = '0; imem_if.imem_error = 1'b0;
        @(negedge clk);
        test_reset();
        test_jump();
        test_ret();
        test_stall_bubble();
        test_status();
        test_call_wrap();
`ifdef PIPE_FETCH_PERF_EN
        test_perf();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_fetch_stage.md
Name: pipe_fetch_stage

Overview:
- Y86-64 fetch stage plus the F and D pipeline registers.
- Selects the next PC and splits instruction bytes into icode/ifun/rA/rB/valC.
- Computes valP and the predicted PC, and drives the Decode-stage register fields.
- Consumes F_stall, D_stall and D_bubble from the pipeline control logic, and the M/W redirect sources for mispredicted jumps and ret.

Parameters:
- PC_W, 64, width of PC, valC and valP.
- RESET_PC, 0, value loaded into F_predPC on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- F_stall  input  1  hold F_predPC
- D_stall  input  1  hold all D_* registers
- D_bubble  input  1  load a nop bubble into D_*
- M_icode  input  4  icode in Memory stage
- M_Cnd  input  1  condition outcome of the jump in Memory stage
- M_valA  input  PC_W  fall-through PC of the jump in Memory stage
- W_icode  input  4  icode in Writeback stage
- W_valM  input  PC_W  return address popped by ret
- imem_addr  output  PC_W  fetch address, equal to f_pc
- imem_data  input  80  bytes f_pc..f_pc+9, byte0 in bits [7:0]
- imem_error  input  1  fetch address invalid
- f_predPC  output  PC_W  combinational predicted PC, for debug
- D_stat  output  3  status: AOK=1, HLT=2, ADR=3, INS=4
- D_icode  output  4  decode icode
- D_ifun  output  4  decode ifun
- D_rA  output  4  register A
- D_rB  output  4  register B
- D_valC  output  PC_W  constant word
- D_valP  output  PC_W  incremented PC

Behaviour:
- PC select (combinational):
  - M_icode==7 && !M_Cnd -> f_pc=M_valA.
  - Else W_icode==9 -> f_pc=W_valM.
  - Else f_pc=F_predPC.
- Split fields:
  - icode=byte0[7:4], ifun=byte0[3:0].
  - imem_error forces icode=1 (nop) and ifun=0.
- Valid icodes are 0..B. An invalid icode gives instr_valid=0.
- need_regids for icode in {2,3,4,5,6,A,B}.
- need_valC for icode in {3,4,5,7,8}.
- rA/rB:
  - Taken from byte1[7:4]/[3:0] when need_regids.
  - Otherwise both are 4'hF.
- valC (8 bytes, little-endian):
  - Bytes 1..8 if need_regids is 0.
  - Bytes 2..9 if need_regids is 1.
  - Zero if need_valC is 0.
- Length: valP = f_pc + 1 + need_regids + 8*need_valC, so 1/2/9/10. Modulo 2^PC_W wrap.
- Prediction: f_predPC = valC for icode 7 or 8, else valP.
- Status, in priority order: imem_error -> ADR; !instr_valid -> INS; icode==0 -> HLT; else AOK.
- F register:
  - Reset: F_predPC=RESET_PC.
  - On clk: hold if F_stall, else load f_predPC.
- D register, on clk:
  - D_stall=1: hold all fields. Stall has priority over a simultaneous bubble.
  - Else D_bubble=1: load bubble.
  - Else load fetched fields.
- Bubble / reset value: stat=AOK, icode=1, ifun=0, rA=rB=F, valC=0, valP=0.
- Reset is asynchronous. Asserting rst_n=0 mid-operation forces F_predPC and all D_* to reset values immediately, independent of clk.
- Latency: an instruction at f_pc appears on D_* one cycle later.
- No internal FSM beyond the registers. Redirect, stall and bubble are single-cycle decisions made every clock.

Optional Feature:
- Macro PIPE_FETCH_PERF_EN.
- When defined, adds outputs perf_fetched[31:0] and perf_bubbles[31:0], both reset to 0:
  - perf_fetched increments on each clk where D loads fetched fields (!D_stall && !D_bubble).
  - perf_bubbles increments on each clk where D loads a bubble (!D_stall && D_bubble).
  - Both counters wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - RNONE=F.
  - Status codes SAOK, SHLT, SADR, SINS.
- One natural sub-module: fetch_align, a combinational split of imem_data into fields, valC, need_regids, need_valC and instr_valid.
- PC select and the registers stay in the top module.

Test Plan:
- Reset: rst_n=0 with clk running -> imem_addr=RESET_PC, D_icode=1, D_stat=1, D_rA=F. Release; imem_data byte0=0x30 (irmovq), byte1=0xF2, valC=0x100 -> next cycle D_icode=3, D_rB=2, D_valC=0x100, D_valP=10, F_predPC=10.
- Jump prediction: fetch jmp (0x70) at PC 0x20 with dest 0x80 -> D_valP=0x29, next imem_addr=0x80. Then M_icode=7, M_Cnd=0, M_valA=0x29 -> imem_addr=0x29 that cycle.
- Ret: W_icode=9, W_valM=0x400, F_stall=1 held -> imem_addr=0x400 while F_predPC unchanged. Bubble in D gives D_icode=1.
- Stall vs bubble: D_stall=1 and D_bubble=1 together -> D_* hold the prior instruction. D_bubble alone -> nop bubble values.
- Status: imem_error=1 -> D_stat=3, D_icode=1. byte0=0xC0 -> D_stat=4. byte0=0x00 -> D_stat=2, D_valP=PC+1.
- Perf (PIPE_FETCH_PERF_EN): 5 loads, 2 bubbles, 1 stall -> perf_fetched=5, perf_bubbles=2. Async reset mid-run -> both counters 0.
